// File: rtl/serial_frame_ctrl_if.sv
// Handshake/bus bundle between the serial frame controller, its paired
// 2-bit length counter and the downstream demux.
interface serial_frame_ctrl_if #(
    parameter int PORT_W = 2
);
    logic              clk_en;
    logic              sin;
    logic              cnt_co;
    logic              cnt_en;
    logic              cnt_rst;
    logic [PORT_W-1:0] port_num;
    logic              data_bit;
    logic              data_valid;
    logic              busy;
    logic              done;

    modport master (
        output clk_en, sin, cnt_co,
        input  cnt_en, cnt_rst, port_num, data_bit, data_valid, busy, done
    );

    modport slave (
        input  clk_en, sin, cnt_co,
        output cnt_en, cnt_rst, port_num, data_bit, data_valid, busy, done
    );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial frame parser: start bit, port field, 4-bit length, data bits.
// Data bits leave registered one edge after their sample; done trails the last by one clk.
module serial_frame_ctrl #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_frame_ctrl_if.slave  bus
);
    localparam int IDX_W = (PORT_W > 1) ? $clog2(PORT_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PORT,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PORT_W-1:0]  port_q;
    logic [LEN_W-2:0]   len_q;
    logic [LEN_W-1:0]   rem_q;
    logic               data_bit_q;
    logic               data_valid_q;
    logic               done_q;

    logic [PORT_W-1:0]  port_d;
    logic [LEN_W-1:0]   len_d;

    // The length only needs LEN_W-1 stored bits: the last one is taken live from sin.
    assign port_d = {port_q[PORT_W-2:0], bus.sin};
    assign len_d  = {len_q, bus.sin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            port_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            data_bit_q   <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clk_en && !bus.sin) begin
                        idx_q   <= '0;
                        state_q <= PORT;
                    end
                end
                PORT: begin
                    if (bus.clk_en) begin
                        port_q <= port_d;
                        idx_q  <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(PORT_W - 1)) begin
                            state_q <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (bus.clk_en) begin
                        len_q <= len_d[LEN_W-2:0];
                        if (bus.cnt_co) begin
                            if (len_d == '0) begin
                                state_q <= DONE;
                            end else begin
                                rem_q   <= len_d;
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (bus.clk_en) begin
                        data_bit_q   <= bus.sin;
                        data_valid_q <= 1'b1;
                        rem_q        <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // done lands one clk after the last data_valid, never alongside it
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cnt_en     = (state_q == LEN);
    assign bus.cnt_rst    = (state_q != LEN);
    assign bus.busy       = (state_q != IDLE);
    assign bus.port_num   = port_q;
    assign bus.data_bit   = data_bit_q;
    assign bus.data_valid = data_valid_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: paired 2-bit counter model, directed and random frames.
module tb_serial_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_ctrl_if #(.PORT_W(2)) bus ();

    serial_frame_ctrl #(.PORT_W(2), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Companion 2-bit up-counter with synchronous clear.
    logic [1:0] cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= 2'd0;
        else if (bus.cnt_rst)             cnt <= 2'd0;
        else if (bus.cnt_en && bus.clk_en) cnt <= cnt + 2'd1;
    end
    assign bus.cnt_co = (cnt == 2'd3);

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_sample_cyc = 0;

    int obs_q[$];
    int exp_q[$];
    int done_cnt, done_cyc, last_dv_cyc, cnten_cnt, len_idx;
    int width_err, overlap_err, co_err;
    bit prev_en = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_valid) begin
                obs_q.push_back(int'({bus.port_num, bus.data_bit}));
                last_dv_cyc = cyc;
                if (!prev_en) width_err++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.data_valid && bus.done) overlap_err++;
            if (bus.cnt_en && bus.clk_en) begin
                cnten_cnt++;
                len_idx++;
                if (bus.cnt_co != (len_idx == 4)) co_err++;
            end else if (!bus.cnt_en) begin
                len_idx = 0;
            end
        end
        prev_en = bus.clk_en;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick(input bit en, input bit s);
        bus.clk_en = en;
        bus.sin    = s;
        @(posedge clk);
        #1;
        bus.clk_en = 1'b0;
    endtask

    task automatic sample(input bit s, input int per);
        for (int i = 0; i < per - 1; i++) tick(1'b0, s);
        tick(1'b1, s);
        last_sample_cyc = cyc;
    endtask

    task automatic clear_mon();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0; done_cyc = -1; last_dv_cyc = -1; cnten_cnt = 0;
        width_err = 0; overlap_err = 0; co_err = 0;
    endtask

    // Reference: a frame yields one {port,bit} item per data bit, in order.
    task automatic add_exp(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
        for (int i = 0; i < int'(l); i++) exp_q.push_back(int'({p, d[i]}));
    endtask

    task automatic send_frame(input logic [1:0] p, input logic [3:0] l,
                              input logic [14:0] d, input int per);
        sample(1'b0, per);
        sample(p[1], per);
        sample(p[0], per);
        for (int i = 3; i >= 0; i--) sample(l[i], per);
        for (int i = 0; i < int'(l); i++) sample(d[i], per);
        bus.sin = 1'b1;
    endtask

    task automatic check_result(input string tag, input int ndone, input logic [1:0] p_final,
                                input logic [3:0] l_last);
        int n;
        int lsc;
        lsc = last_sample_cyc;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        check({tag, " dv_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) check($sformatf("%s item%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, " done_count"}, done_cnt, ndone);
        check({tag, " done_timing"}, done_cyc, lsc + 1);
        if (l_last != 4'd0) check({tag, " last_dv_timing"}, last_dv_cyc, lsc);
        check({tag, " cnt_en_samples"}, cnten_cnt, 4 * ndone);
        check({tag, " dv_width_err"}, width_err, 0);
        check({tag, " dv_done_overlap"}, overlap_err, 0);
        check({tag, " cnt_co_order"}, co_err, 0);
        check({tag, " busy_end"}, int'(bus.busy), 0);
        check({tag, " port_num"}, int'(bus.port_num), int'(p_final));
    endtask

    initial begin
        logic [1:0]  p;
        logic [3:0]  l;
        logic [14:0] d;
        int          per;

        bus.clk_en = 1'b0;
        bus.sin    = 1'b1;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst data_valid", int'(bus.data_valid), 0);
        check("rst done",       int'(bus.done), 0);
        check("rst port_num",   int'(bus.port_num), 0);
        check("rst busy",       int'(bus.busy), 0);
        check("rst cnt_en",     int'(bus.cnt_en), 0);
        check("rst cnt_rst",    int'(bus.cnt_rst), 1);
        rst = 1'b0;

        // Idle line with the strobe running must never start a frame.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check("idle busy",    int'(bus.busy), 0);
        check("idle cnt_en",  int'(bus.cnt_en), 0);
        check("idle cnt_rst", int'(bus.cnt_rst), 1);
        check("idle dv",      obs_q.size(), 0);
        check("idle done",    done_cnt, 0);

        clear_mon();
        add_exp(2'b10, 4'd3, 15'b101);
        send_frame(2'b10, 4'd3, 15'b101, 1);
        check_result("f_len3", 1, 2'b10, 4'd3);

        clear_mon();
        add_exp(2'b01, 4'd0, 15'd0);
        send_frame(2'b01, 4'd0, 15'd0, 4);
        check_result("f_len0", 1, 2'b01, 4'd0);

        clear_mon();
        add_exp(2'b11, 4'd15, 15'b101010101010101);
        send_frame(2'b11, 4'd15, 15'b101010101010101, 3);
        check_result("f_len15", 1, 2'b11, 4'd15);

        // Reset after two of five data bits; the second data_valid is still pending.
        clear_mon();
        sample(1'b0, 1); sample(1'b0, 1); sample(1'b1, 1);
        sample(1'b0, 1); sample(1'b1, 1); sample(1'b0, 1); sample(1'b1, 1);
        sample(1'b1, 1); sample(1'b0, 1);
        rst = 1'b1;
        #1;
        check("midrst data_valid", int'(bus.data_valid), 0);
        check("midrst done",       int'(bus.done), 0);
        check("midrst port_num",   int'(bus.port_num), 0);
        check("midrst busy",       int'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("midrst no_done", done_cnt, 0);
        check("midrst cnt_rst", int'(bus.cnt_rst), 1);
        clear_mon();
        add_exp(2'b11, 4'd2, 15'b10);
        send_frame(2'b11, 4'd2, 15'b10, 2);
        check_result("f_after_rst", 1, 2'b11, 4'd2);

        // Back-to-back: a low sin in the DONE cycle must be ignored.
        clear_mon();
        add_exp(2'b01, 4'd3, 15'b011);
        add_exp(2'b10, 4'd2, 15'b01);
        send_frame(2'b01, 4'd3, 15'b011, 1);
        tick(1'b1, 1'b0);
        send_frame(2'b10, 4'd2, 15'b01, 1);
        check_result("f_b2b", 2, 2'b10, 4'd2);

        for (int k = 0; k < 10; k++) begin
            p   = 2'($urandom_range(0, 3));
            l   = 4'($urandom_range(0, 15));
            d   = 15'($urandom);
            per = $urandom_range(1, 4);
            clear_mon();
            add_exp(p, l, d);
            send_frame(p, l, d, per);
            check_result($sformatf("rand%0d", k), 1, p, l);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
